// File: rtl/calc_sequencer.sv
// Sequencing controller for the 8-bit add/subtract calculator: operand latch,
// adder result capture, 9-step double-dabble and 4-digit multiplexed display scan.
module calc_sequencer #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_sel,
  input  logic [7:0] add_s,
  input  logic       add_cout,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd,
  output logic [1:0] sel_disp,
  output logic [3:0] an
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_CONV    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [2:0]    state_q, state_d;
  logic          start_q;
  logic [7:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic          op_sub_q, op_sub_d;
  logic [8:0]    mag_q, mag_d;
  logic          neg_q, neg_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    dd_q, dd_d;
  logic [9:0]    dd_adj;
  logic [10:0]   dd_shift;
  logic [3:0]    d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, dsign_q, dsign_d;
  logic [DW-1:0] div_q;
  logic [1:0]    sel_q;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Hundreds never exceeds 2 before the last step, so the working register keeps
  // only 2 hundreds bits; the full 3-bit hundreds digit exists only in dd_shift.
  always_comb begin
    dd_adj   = {dd_q[9:8], dabble(dd_q[7:4]), dabble(dd_q[3:0])};
    dd_shift = {dd_adj, mag_q[8]};
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_sub_d = op_sub_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    dd_d     = dd_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    dsign_d  = dsign_q;
    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          state_d  = S_LOAD;
          op_a_d   = a;
          op_b_d   = b;
          op_sub_d = sub;
        end
      end
      S_LOAD: state_d = S_CAPTURE;
      S_CAPTURE: begin
        state_d = S_CONV;
        mag_d   = op_sub_q ? {1'b0, add_s} : {add_cout, add_s};
        neg_d   = op_sub_q & ~add_cout;
        cnt_d   = '0;
        dd_d    = '0;
      end
      S_CONV: begin
        dd_d  = dd_shift[9:0];
        mag_d = {mag_q[7:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          state_d = S_DONE;
          d0_d    = dd_shift[3:0];
          d1_d    = dd_shift[7:4];
          d2_d    = {1'b0, dd_shift[10:8]};
          dsign_d = neg_q ? 4'd10 : 4'd11;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sub_q <= 1'b0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      dd_q     <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      dsign_q  <= 4'd11;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_sub_q <= op_sub_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      dd_q     <= dd_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      dsign_q  <= dsign_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      sel_q <= '0;
    end else if (div_q == DIV_MAX) begin
      div_q <= '0;
      sel_q <= sel_q + 2'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Slot order follows the board wiring: units, sign, hundreds, tens.
  always_comb begin
    case (sel_q)
      2'd0:    bcd = d0_q;
      2'd1:    bcd = dsign_q;
      2'd2:    bcd = d2_q;
      default: bcd = d1_q;
    endcase
  end

  assign an       = ~(4'b0001 << sel_q);
  assign sel_disp = sel_q;
  assign add_a    = op_a_q;
  assign add_b    = op_b_q;
  assign add_sel  = op_sub_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a behavioural sumres8b model.
module tb_calc_sequencer;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] add_a, add_b, add_s;
  logic       add_sel, add_cout, busy, done;
  logic [3:0] bcd, an;
  logic [1:0] sel_disp;

  calc_sequencer #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .add_a(add_a), .add_b(add_b), .add_sel(add_sel), .add_s(add_s),
    .add_cout(add_cout), .busy(busy), .done(done), .bcd(bcd),
    .sel_disp(sel_disp), .an(an)
  );

  always #5 clk = ~clk;

  // sumres8b: sum with carry, or |A-B| with Cout = (A >= B)
  always_comb begin
    if (add_sel) begin
      add_cout = (add_a >= add_b);
      add_s    = add_cout ? add_a - add_b : add_b - add_a;
    end else begin
      {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};
    end
  end

  // {sign, hundreds, tens, units}
  function automatic logic [15:0] expect_digits(input logic [7:0] fa, input logic [7:0] fb,
                                                input logic fs);
    int unsigned m;
    logic neg;
    neg = fs && (fa < fb);
    if (!fs)     m = int'(fa) + int'(fb);
    else if (neg) m = int'(fb) - int'(fa);
    else          m = int'(fa) - int'(fb);
    return {neg ? 4'd10 : 4'd11, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Reference model: an accepted request keeps the unit busy for 12 cycles.
  int          busy_left;
  logic        prev_start;
  logic [7:0]  m_a, m_b;
  logic        m_sub;
  int unsigned n_edges;
  logic [15:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left  <= 0;
      prev_start <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
      m_sub      <= 1'b0;
      n_edges    <= 0;
      exp_q.delete();
    end else begin
      n_edges    <= n_edges + 1;
      prev_start <= start;
      if (busy_left == 0) begin
        if (start && !prev_start) begin
          busy_left <= 12;
          m_a       <= a;
          m_b       <= b;
          m_sub     <= sub;
          exp_q.push_back(expect_digits(a, b, sub));
        end
      end else begin
        busy_left <= busy_left - 1;
      end
    end
  end

  int          n_checks = 0;
  int          n_fail = 0;
  int          tmo_cnt = 0;
  bit          end_req = 1'b0;
  bit          end_ack = 1'b0;
  logic [3:0]  disp_m [4];
  logic [15:0] e;
  int unsigned sel_exp;
  logic [3:0]  an_exp;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      disp_m[0] = 4'd0;
      disp_m[1] = 4'd11;
      disp_m[2] = 4'd0;
      disp_m[3] = 4'd0;
    end else if (done) begin
      check("done_has_expect", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        disp_m[0] = e[3:0];
        disp_m[1] = e[15:12];
        disp_m[2] = e[11:8];
        disp_m[3] = e[7:4];
      end
    end
    sel_exp = (n_edges / SD) % 4;
    an_exp  = ~(4'b0001 << sel_exp);
    check("sel_disp", sel_disp, sel_exp);
    check("an", an, an_exp);
    check("bcd", bcd, disp_m[sel_exp]);
    check("busy", busy, int'(busy_left > 0));
    check("done", done, int'(busy_left == 1));
    check("add_a", add_a, m_a);
    check("add_b", add_b, m_b);
    check("add_sel", add_sel, m_sub);
    if (end_req && !end_ack) begin
      check("queue_empty", exp_q.size(), 0);
      check("timeouts", tmo_cnt, 0);
      end_ack = 1'b1;
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo_cnt++;
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        input int hold);
    @(negedge clk);
    a = ta;
    b = tb;
    sub = ts;
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(8'd200, 8'd100, 1'b0, 2);
    run_op(8'd5,   8'd9,   1'b1, 1);
    run_op(8'd255, 8'd255, 1'b0, 3);
    run_op(8'd0,   8'd0,   1'b0, 1);
    run_op(8'd0,   8'd255, 1'b1, 1);
    run_op(8'd255, 8'd0,   1'b1, 1);
    run_op(8'd77,  8'd77,  1'b1, 1);

    repeat (20) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 20)));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    // start held high long past completion, then a mid-operation toggle
    @(negedge clk);
    a = 8'd123; b = 8'd45; sub = 1'b1; start = 1'b1;
    repeat (50) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'd9; b = 8'd99; sub = 1'b0; start = 1'b1;
    repeat (5) @(negedge clk);
    a = 8'd1; b = 8'd2;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_idle();
    start = 1'b0;
    repeat (3) @(negedge clk);

    // rise coincident with DONE is ignored
    @(negedge clk);
    a = 8'd60; b = 8'd61; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    if (!done) tmo_cnt++;
    a = 8'd200; b = 8'd1; sub = 1'b0; start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // reset during CONV aborts and clears the display
    @(negedge clk);
    a = 8'd150; b = 8'd150; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3 * SD * 4) @(negedge clk);

    run_op(8'd17, 8'd3, 1'b1, 1);
    repeat (2 * SD * 4) @(negedge clk);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
    if (!end_ack) begin
      $display("FAIL end_handshake: got 0 expected 1");
      $fatal(1, "monitor did not acknowledge end of test");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
